mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the 8-bit data memory.
- Accepts byte/halfword/word load and store requests from the CPU core.
- Splits each request into sequential single-byte memory cycles (little-endian), assembles and extends load results, and signals completion with a one-cycle pulse.
- Drives the memory's address, write data and active-low write enable.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  ADDR_W  base byte address.
- wdata  input  32  store data; the low 1/2/4 bytes are used.
- busy  output  1  high in ACCESS and DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = illegal size.
- rdata  output  32  load result; holds until the next load completes.
- mem_addr  output  ADDR_W  to memory address.
- mem_wdata  output  8  to memory write data.
- mem_wren  output  1  to memory write enable, active-low (0 = write at posedge).
- mem_rdata  input  8  from memory combinational read data.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State returns to IDLE and the byte counter clears.
  - busy=0, done=0, err=0, rdata=0, mem_wren=1, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts immediately. Bytes already written stay in memory; no done pulse is produced.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Memory outputs are mem_addr=0, mem_wdata=0, mem_wren=1. No write is ever issued from IDLE.
  - On req=1 with size!=11: latch addr, wdata, we, sign and size; set n = 1/2/4 bytes; clear counter k; go to ACCESS.
  - On req=1 with size==11: no memory cycle; go to DONE with err=1; rdata unchanged.
- ACCESS, one byte per cycle:
  - mem_addr = (latched addr + k) mod 2^ADDR_W. Combinational from registers; stable for the whole cycle.
  - Store: mem_wdata = wdata[8k+7:8k] and mem_wren=0.
  - Load: mem_wdata=0 and mem_wren=1; mem_rdata is captured into buffer byte k at the cycle-ending posedge.
  - If k==n-1, go to DONE. On that same edge, for loads, rdata is updated:
    - Assemble bytes 0..n-1 little-endian.
    - Extend to 32 bits from bit 7 (byte) or bit 15 (halfword), according to sign.
    - Word loads are not extended.
  - Otherwise k increments.
- DONE:
  - done=1 for exactly one cycle; err is valid in this cycle. mem_wren=1.
  - Next state is IDLE unconditionally.
  - err clears on leaving DONE.
- Latency: req sampled at edge E0; done is high in the cycle after edge E0+n, i.e. 2/3/5 cycles after req for byte/half/word. Illegal size: done in the cycle after E0.
- req while busy is ignored. It is neither queued nor does it alter latched operands.
- Stores leave rdata unchanged.
- No alignment restriction. An access starting at 0xFF continues at 0x00.
- Input changes on addr/wdata/we/size/sign after acceptance have no effect on the transaction in flight.

Test Plan:
- Word store 0x87654321 to addr 0x10, then word load from 0x10:
  - Memory holds 0x21,0x43,0x65,0x87 at 0x10..0x13.
  - mem_wren=0 for exactly 4 cycles.
  - Load returns rdata=0x87654321, with done 5 cycles after req.
- Byte store 0xA9 to 0x20:
  - Load byte sign=1 -> rdata=0xFFFFFFA9.
  - Load byte sign=0 -> rdata=0x000000A9.
  - done 2 cycles after req.
- Halfword store 0x8001 at 0xFF:
  - Memory[0xFF]=0x01 and memory[0x00]=0x80 (address wrap).
  - Signed halfword load from 0xFF -> rdata=0xFFFF8001.
- size=11 request:
  - done with err=1 one cycle later.
  - mem_wren stays 1 throughout; rdata unchanged from the previous load.
- Reset mid-operation: word store of 0xDDCCBBAA to 0x40, with rst_n=0 for one cycle after 2 bytes written:
  - memory[0x40]=0xAA, [0x41]=0xBB; [0x42] and [0x43] untouched.
  - busy=0 and mem_wren=1 after the reset edge; no done pulse.
- Second req with different addr/wdata asserted during a busy word load:
  - Ignored. Only one done pulse; rdata matches the first request.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-serial little-endian load/store sequencer for an 8-bit data memory
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wren,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state, state_nx;
  logic [1:0]        k, sz;
  logic [ADDR_W-1:0] base;
  logic [31:0]       data, load_val;
  logic [23:0]       buffer;
  logic              st, sgn, last;
  assign last = k == {sz[1], |sz};
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE   ? (req ? (size == 2'b11 ? DONE : ACCESS) : IDLE) :
               state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      k     <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      err <= state == IDLE && req && size == 2'b11;
      if (state == IDLE && req) begin
        base <= addr;
        data <= wdata;
        st   <= we;
        sgn  <= sign;
        sz   <= size;
        k    <= '0;
      end
      if (state == ACCESS) begin
        k      <= k + 2'd1;
        buffer <= {mem_rdata, buffer[23:8]};
        if (last && !st) rdata <= load_val;
      end
    end
  assign load_val  = sz == 2'b00 ? {{24{sgn & mem_rdata[7]}}, mem_rdata} :
                     sz == 2'b01 ? {{16{sgn & mem_rdata[7]}}, mem_rdata, buffer[23:16]} :
                                   {mem_rdata, buffer};
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign mem_addr  = state == ACCESS ? base + ADDR_W'(k) : '0;
  assign mem_wdata = state == ACCESS && st ? data[{k, 3'b000} +: 8] : '0;
  assign mem_wren  = !(state == ACCESS && st);
endmodule
